// File: rtl/scene_restoration_pipe.sv
// Scene-radiance restoration J = A + (I - A) * t_inv, three-stage valid/ready pipeline
// with per-channel clamping, bypass and per-frame clip statistics.

module scene_restoration_lane #(
    parameter int PIX_W  = 8,
    parameter int T_W    = 12,
    parameter int T_FRAC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] hazy,
    input  logic [PIX_W-1:0] air,
    input  logic [T_W-1:0]   t1,
    input  logic             byp2,
    output logic [PIX_W-1:0] res,
    output logic             clip_hi,
    output logic             clip_lo
);
    localparam int P_W = PIX_W + T_W;
    localparam int W   = P_W + 1;

    logic [PIX_W:0]   d, d_neg;
    logic             sgn1, sgn2;
    logic [PIX_W-1:0] mag1, a1, i1, a2, i2;
    logic [P_W-1:0]   p2;
    logic [W-1:0]     m, r;
    logic             hi_n, lo_n;
    logic [PIX_W-1:0] res_n;

    assign d     = {1'b0, hazy} - {1'b0, air};
    assign d_neg = -d;

    // Rounded magnitude of the correction, then A +/- m; the extra top bits of r
    // carry overflow (positive side) or borrow (negative side) for clamping.
    always_comb begin
        m     = ({1'b0, p2} + W'(2 ** (T_FRAC - 1))) >> T_FRAC;
        r     = sgn2 ? (W'(a2) - m) : (W'(a2) + m);
        hi_n  = ~sgn2 & (|r[W-1:PIX_W]);
        lo_n  = sgn2 & r[W-1];
        res_n = r[PIX_W-1:0];
        if (hi_n) res_n = '1;
        if (lo_n) res_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn1 <= 1'b0; mag1 <= '0; a1 <= '0; i1 <= '0;
            sgn2 <= 1'b0; p2 <= '0; a2 <= '0; i2 <= '0;
            res <= '0; clip_hi <= 1'b0; clip_lo <= 1'b0;
        end else if (en) begin
            sgn1 <= d[PIX_W];
            mag1 <= d[PIX_W] ? d_neg[PIX_W-1:0] : d[PIX_W-1:0];
            a1   <= air;
            i1   <= hazy;
            sgn2 <= sgn1;
            p2   <= P_W'(mag1) * P_W'(t1);
            a2   <= a1;
            i2   <= i1;
            if (byp2) begin
                res     <= i2;
                clip_hi <= 1'b0;
                clip_lo <= 1'b0;
            end else begin
                res     <= res_n;
                clip_hi <= hi_n;
                clip_lo <= lo_n;
            end
        end
    end
endmodule

module scene_restoration_pipe #(
    parameter int PIX_W  = 8,
    parameter int NCH    = 3,
    parameter int T_W    = 12,
    parameter int T_FRAC = 8,
    parameter int CNT_W  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic                 bypass,
    input  logic [NCH*PIX_W-1:0] hazy_i,
    input  logic [NCH*PIX_W-1:0] air_i,
    input  logic [T_W-1:0]       t_inv_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic [NCH*PIX_W-1:0] dehazed_o,
    output logic [CNT_W-1:0]     clip_hi_cnt,
    output logic [CNT_W-1:0]     clip_lo_cnt
);
    localparam int STAGES = 3;

    logic [STAGES:1]             vld_pipe, sof_pipe;
    logic                        byp1, byp2;
    logic [T_W-1:0]              t1;
    logic                        en, xfer;
    logic [NCH-1:0][PIX_W-1:0]   res_lane;
    logic [NCH-1:0]              hi_vec, lo_vec;
    logic [CNT_W:0]              hi_beat, lo_beat, hi_acc, lo_acc;
    logic [CNT_W-1:0]            hi_nxt, lo_nxt;

    assign en        = ~(vld_pipe[STAGES] & ~out_ready);
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign out_sof   = sof_pipe[STAGES];
    assign dehazed_o = res_lane;
    assign xfer      = vld_pipe[STAGES] & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            sof_pipe <= '0;
            byp1     <= 1'b0;
            byp2     <= 1'b0;
            t1       <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            sof_pipe <= {sof_pipe[STAGES-1:1], in_valid & in_sof};
            byp1     <= bypass;
            byp2     <= byp1;
            t1       <= t_inv_i;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        scene_restoration_lane #(.PIX_W(PIX_W), .T_W(T_W), .T_FRAC(T_FRAC)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .hazy    (hazy_i[c*PIX_W +: PIX_W]),
            .air     (air_i[c*PIX_W +: PIX_W]),
            .t1      (t1),
            .byp2    (byp2),
            .res     (res_lane[c]),
            .clip_hi (hi_vec[c]),
            .clip_lo (lo_vec[c])
        );
    end

    // An SOF transfer restarts the frame's tally with its own clips; saturate otherwise.
    always_comb begin
        hi_beat = '0;
        lo_beat = '0;
        for (int c = 0; c < NCH; c++) begin
            hi_beat = hi_beat + (CNT_W+1)'(hi_vec[c]);
            lo_beat = lo_beat + (CNT_W+1)'(lo_vec[c]);
        end
        hi_acc = out_sof ? hi_beat : ({1'b0, clip_hi_cnt} + hi_beat);
        lo_acc = out_sof ? lo_beat : ({1'b0, clip_lo_cnt} + lo_beat);
        hi_nxt = hi_acc[CNT_W] ? '1 : hi_acc[CNT_W-1:0];
        lo_nxt = lo_acc[CNT_W] ? '1 : lo_acc[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_hi_cnt <= '0;
            clip_lo_cnt <= '0;
        end else if (xfer) begin
            clip_hi_cnt <= hi_nxt;
            clip_lo_cnt <= lo_nxt;
        end
    end
endmodule

// File: tb/tb_scene_restoration_pipe.sv
// Directed bench for scene_restoration_pipe: arithmetic, clamping, rounding, stall,
// clip statistics, bypass and mid-stream reset, all against hand-computed values.
module tb_scene_restoration_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sof, bypass;
    logic [23:0] hazy_i, air_i, dehazed_o;
    logic [11:0] t_inv_i;
    logic        out_valid, out_ready, out_sof;
    logic [19:0] clip_hi_cnt, clip_lo_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scene_restoration_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .bypass(bypass),
        .hazy_i(hazy_i), .air_i(air_i), .t_inv_i(t_inv_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .dehazed_o(dehazed_o), .clip_hi_cnt(clip_hi_cnt), .clip_lo_cnt(clip_lo_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with an empty pipe; ends at the negedge after the output transfer.
    task automatic beat(input string tag, input logic [23:0] h, input logic [23:0] a,
                        input logic [11:0] t, input logic byp, input logic sof,
                        input logic [23:0] exp);
        in_valid = 1'b1; hazy_i = h; air_i = a; t_inv_i = t; bypass = byp; in_sof = sof;
        out_ready = 1'b1;
        #1 check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; bypass = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_j"}, 32'(dehazed_o), 32'(exp));
        check({tag, "_sof"}, 32'(out_sof), 32'(sof));
        @(negedge clk);
    endtask

    task automatic cnt(input string tag, input int hi, input int lo);
        check({tag, "_hi"}, 32'(clip_hi_cnt), 32'(hi));
        check({tag, "_lo"}, 32'(clip_lo_cnt), 32'(lo));
    endtask

    function automatic logic [23:0] spix(input int k);
        return 24'(k) * 24'h0A0B0C + 24'h010203;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int tx, rx;
        logic [23:0] prev;
        logic prev_stall;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; bypass = 1'b0;
        hazy_i = '0; air_i = '0; t_inv_i = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_sof", 32'(out_sof), 32'd0);
        check("rst_j", 32'(dehazed_o), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        cnt("rst", 0, 0);

        // 200,100,t=2.0 -> 100+200 clamps high on all channels
        beat("hi_clip", 24'hC8C8C8, 24'h646464, 12'd512, 1'b0, 1'b1, 24'hFFFFFF);
        cnt("hi_clip", 3, 0);
        beat("neg_t1", 24'h323232, 24'hC8C8C8, 12'd256, 1'b0, 1'b0, 24'h323232);
        cnt("neg_t1", 3, 0);
        beat("lo_clip", 24'h323232, 24'hC8C8C8, 12'd384, 1'b0, 1'b0, 24'h000000);
        cnt("lo_clip", 3, 3);
        // ch0 101->102, ch1 99->98, ch2 d=0 -> 100
        beat("round", 24'h646365, 24'h646464, 12'd384, 1'b0, 1'b0, 24'h646266);
        beat("t_zero", 24'h0A0A0A, 24'h4D4D4D, 12'd0, 1'b0, 1'b0, 24'h4D4D4D);
        beat("bypass", 24'h563412, 24'h000000, 12'd512, 1'b1, 1'b0, 24'h563412);
        cnt("bypass", 3, 3);
        // exact 255 and exact 0 on the boundary are not clips
        beat("edge_eq", 24'h0000FF, 24'hFF64C8, 12'd256, 1'b0, 1'b0, 24'h0000FF);
        cnt("edge_eq", 3, 3);

        beat("fr_p0", 24'h6464C8, 24'h646464, 12'd512, 1'b0, 1'b1, 24'h6464FF);
        cnt("fr_p0", 1, 0);
        beat("fr_p1", 24'h646432, 24'h6464C8, 12'd384, 1'b0, 1'b0, 24'h646400);
        beat("fr_p2", 24'h6464C8, 24'h646464, 12'd512, 1'b0, 1'b0, 24'h6464FF);
        beat("fr_p3", 24'h646464, 24'h646464, 12'd512, 1'b0, 1'b0, 24'h646464);
        cnt("fr_end", 2, 1);
        beat("fr2_sof", 24'h101010, 24'h101010, 12'd256, 1'b0, 1'b1, 24'h101010);
        cnt("fr2_sof", 0, 0);

        // 10-beat stream, out_ready low for cycles 4..7; t=1.0 makes J equal I
        tx = 0; rx = 0; prev = '0; prev_stall = 1'b0;
        air_i = 24'h808080; t_inv_i = 12'd256; in_sof = 1'b0; bypass = 1'b0;
        for (int cyc = 0; cyc < 40 && rx < 10; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (tx < 10);
            hazy_i    = spix(tx);
            #1;
            if (out_valid && !out_ready) begin
                check("stall_rdy", 32'(in_ready), 32'd0);
                if (prev_stall) check("stall_hold", 32'(dehazed_o), 32'(prev));
            end
            if (out_valid && out_ready) begin
                check("stream_j", 32'(dehazed_o), 32'(spix(rx)));
                rx++;
            end
            if (in_valid && in_ready) tx++;
            prev = dehazed_o;
            prev_stall = out_valid && !out_ready;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_rx", 32'(rx), 32'd10);
        check("stream_tx", 32'(tx), 32'd10);
        cnt("stream", 0, 0);

        beat("pre_rst", 24'hC8C8C8, 24'h646464, 12'd512, 1'b0, 1'b0, 24'hFFFFFF);
        cnt("pre_rst", 3, 0);
        in_valid = 1'b1; hazy_i = 24'h111111; air_i = 24'h222222; t_inv_i = 12'd256;
        @(negedge clk);
        hazy_i = 24'h333333;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        check("mid_rst_j", 32'(dehazed_o), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        cnt("mid_rst", 0, 0);
        beat("post_rst", 24'h0F0E0D, 24'h808080, 12'd256, 1'b0, 1'b0, 24'h0F0E0D);
        @(negedge clk);
        check("post_drain", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
